pipe_stage_reg: RTL

- Parametrised pipeline stage register that replaces the fixed inter-stage registers (IF/ID through MEM/WB) of the 64-bit core.
- Carries a control field plus N payload lanes across one stage boundary, with a valid/ready handshake, flush-to-bubble and optional skid buffering.
- Skid mode decouples in_ready from out_ready without losing throughput.
- Also counts back-pressure stall cycles for performance monitoring.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_skid_entry.sv | 36 +++
 rtl/pipe_stage_reg.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared widths and skid-stage state encoding for the pipeline stage registers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pipe_pkg;

  // Default datapath width of the 64-bit core.
  localparam int XLEN      = 64;
  // Default writeback control width (RegWrite, MemToReg).
  localparam int WB_CTRL_W = 2;

  // Occupancy of a two-entry stage: nothing held, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_entry.sv
// One storage slot (control + payload) with a valid bit and load/clear controls.
// Latency: load appears on q/valid one cycle later.
// Backpressure: none of its own; the owning stage decides when to load or clear.
module pipe_skid_entry #(
  parameter int W = 130
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Valid bit: clear beats load so a kill always wins over a same-cycle capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Contents: zeroed by reset, replaced on load, otherwise held (clear keeps the old value).
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load && !clear) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: control + LANES payload lanes, valid/ready, flush, stall counter.
// Latency: one cycle from in_fire to out_*; one beat per cycle when out_ready is held high.
// Backpressure: SKID=0 ready is combinational on out_ready; SKID=1 ready is a flop (skid slot empty).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = WB_CTRL_W,
  parameter int DATA_W = XLEN,
  parameter int LANES  = 2,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]        stall_cnt
);

  // A beat is stored as {ctrl, data}; ctrl occupies the top CTRL_W bits.
  localparam int PAY_W  = LANES * DATA_W;
  localparam int BEAT_W = CTRL_W + PAY_W;

  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] main_q;
  logic              main_valid;
  logic              in_fire;
  logic              out_fire;

  assign in_beat   = {in_ctrl, in_data};
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;
  assign out_valid = main_valid;

  // Bubbles carry zero control so a stage ignoring valid still does no writeback.
  assign out_ctrl  = main_valid ? main_q[BEAT_W-1 -: CTRL_W] : '0;
  assign out_data  = main_q[PAY_W-1:0];

  generate
    if (SKID == 0) begin : g_reg
      logic main_load;
      logic main_clear;

      // The held beat is either leaving or absent, so a new one may enter.
      assign in_ready   = !main_valid | out_ready;
      // Flush drops a same-cycle arrival; otherwise a drain without refill empties the slot.
      assign main_load  = in_fire & !flush;
      assign main_clear = flush | (out_fire & !in_fire);

      pipe_skid_entry #(.W(BEAT_W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (in_beat),
        .valid (main_valid),
        .q     (main_q)
      );
    end else begin : g_skid
      skid_state_t       state;
      skid_state_t       state_nxt;
      logic              main_load;
      logic              main_clear;
      logic              main_from_skid;
      logic              skid_load;
      logic              skid_clear;
      logic              skid_valid;
      logic [BEAT_W-1:0] skid_q;
      logic [BEAT_W-1:0] main_d;

      // The skid slot's valid bit is a flop and is set exactly in FULL, so ready is registered.
      assign in_ready = !skid_valid;
      // Main refills from the skid slot when draining FULL, else from the input.
      assign main_d   = main_from_skid ? skid_q : in_beat;

      // Occupancy state register.
      always_ff @(posedge clk) begin
        if (rst) begin
          state <= EMPTY;
        end else begin
          state <= state_nxt;
        end
      end

      // Next occupancy and slot controls; flush empties both slots and drops any arrival.
      always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
          state_nxt  = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end else begin
          case (state)
            EMPTY: begin
              if (in_fire) begin
                state_nxt = BUSY;
                main_load = 1'b1;
              end
            end
            BUSY: begin
              if (in_fire && out_fire) begin
                main_load = 1'b1;
              end else if (in_fire) begin
                state_nxt = FULL;
                skid_load = 1'b1;
              end else if (out_fire) begin
                state_nxt  = EMPTY;
                main_clear = 1'b1;
              end
            end
            FULL: begin
              if (out_fire) begin
                state_nxt      = BUSY;
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_clear     = 1'b1;
              end
            end
            default: begin
              state_nxt  = EMPTY;
              main_clear = 1'b1;
              skid_clear = 1'b1;
            end
          endcase
        end
      end

      pipe_skid_entry #(.W(BEAT_W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
      );

      pipe_skid_entry #(.W(BEAT_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_beat),
        .valid (skid_valid),
        .q     (skid_q)
      );
    end
  endgenerate

  // Saturating count of cycles a held beat waits on downstream; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
